// File: rtl/z80_uart_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and serial FSM state type
// for the Z80 I/O-port UART.
package z80_uart_fifo_pkg;
   localparam logic [1:0] REG_STAT = 2'd0;
   localparam logic [1:0] REG_DATA = 2'd1;
   localparam logic [1:0] REG_DIVL = 2'd2;
   localparam logic [1:0] REG_DIVH = 2'd3;

   localparam int ST_RX_NE   = 0;
   localparam int ST_TX_NF   = 1;
   localparam int ST_OVR     = 2;
   localparam int ST_FE      = 3;
   localparam int ST_TX_OVF  = 4;
   localparam int ST_TX_IDLE = 5;
   localparam int ST_IRQ     = 7;

   localparam int CT_RX_IE   = 0;
   localparam int CT_TX_IE   = 1;
   localparam int CT_LOOP    = 2;
   localparam int CT_FLUSH   = 7;

   localparam int DEFAULT_DIV = 162;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
endpackage

// File: rtl/z80_uart_fifo_sync_fifo.sv
// Single-clock FIFO; full/empty from an extra pointer wrap bit.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);
   logic [WIDTH-1:0] mem [2**AW];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head  = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wptr[AW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full)
            wptr <= wptr + 1'b1;
         if (pop && !empty)
            rptr <= rptr + 1'b1;
      end
   end
endmodule

// File: rtl/z80_uart_fifo.sv
// Z80 I/O-port UART: RX/TX FIFOs, programmable x16 baud divisor, maskable IRQ.
// state   | meaning
// S_IDLE  | line idle, waiting (RX: low sample, TX: tick with data queued)
// S_START | start bit (RX: mid-bit verify after 8 ticks, TX: 16 ticks low)
// S_DATA  | 8 data bits, LSB first, 16 ticks each
// S_STOP  | stop bit (RX: sample/push after 16 ticks, TX: 16 ticks high)
module z80_uart_fifo
   import z80_uart_fifo_pkg::*;
#(
   parameter int FIFO_AW   = 4,
   parameter int DIV_W     = 16,
   parameter int RESET_DIV = DEFAULT_DIV
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic [1:0] addr,
   input  logic       rd,
   input  logic       wr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       n_int,
   input  logic       rxd,
   output logic       txd
);
   logic wr_q, rd_q, wr_go, rd_done, flush, stat_clr;
   logic [1:0] rd_addr;
   logic [2:0] ctrl;
   logic ovr, fe, tx_ovf, irq, tx_idle;
   logic [DIV_W-1:0] div, div_n, baud_cnt;
   logic [15:0] div_ext;
   logic tick16, div_wr;
   logic rx_push, rx_pop, rx_empty, rx_full, rx_ovr_set, rx_fe_set;
   logic tx_push, tx_pop, tx_empty, tx_full, txd_n;
   logic [7:0] rx_head, tx_head;
   logic rx_s1, rx_s2;
   uart_state_t rx_state, rx_next, tx_state, tx_next;
   logic [3:0] rx_tcnt, rx_tcnt_n, tx_tcnt, tx_tcnt_n;
   logic [2:0] rx_bit, rx_bit_n, tx_bit, tx_bit_n;
   logic [7:0] rx_sh, rx_sh_n, tx_sh, tx_sh_n;

   // Writes commit on the strobe's rising edge, reads act on its falling edge.
   assign wr_go    = cs & wr & ~wr_q;
   assign rd_done  = rd_q & ~(cs & rd);
   assign flush    = wr_go && (addr == REG_STAT) && din[CT_FLUSH];
   assign stat_clr = rd_done && (rd_addr == REG_STAT);
   assign rx_pop   = rd_done && (rd_addr == REG_DATA) && !rx_empty;
   assign tx_push  = wr_go && (addr == REG_DATA) && !tx_full;
   assign div_wr   = wr_go && ((addr == REG_DIVL) || (addr == REG_DIVH));
   assign div_ext  = 16'(div);
   assign tick16   = (baud_cnt == '0);
   assign tx_idle  = tx_empty && (tx_state == S_IDLE);
   assign irq      = (ctrl[CT_RX_IE] & ~rx_empty) | (ctrl[CT_TX_IE] & tx_idle);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         rd_addr <= '0;
         ctrl    <= '0;
         n_int   <= 1'b1;
      end else begin
         wr_q  <= cs & wr;
         rd_q  <= cs & rd;
         n_int <= ~irq;
         if (cs & rd)
            rd_addr <= addr;
         if (wr_go && (addr == REG_STAT))
            ctrl <= din[2:0];
      end
   end

   always_comb begin
      div_n = div;
      if (wr_go && (addr == REG_DIVL))
         div_n = DIV_W'({div_ext[15:8], din});
      else if (wr_go && (addr == REG_DIVH))
         div_n = DIV_W'({din, div_ext[7:0]});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div      <= DIV_W'(RESET_DIV);
         baud_cnt <= DIV_W'(RESET_DIV);
      end else begin
         div <= div_n;
         if (div_wr || tick16)
            baud_cnt <= div_n;
         else
            baud_cnt <= baud_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         ovr    <= 1'b0;
         fe     <= 1'b0;
         tx_ovf <= 1'b0;
      end else begin
         ovr    <= rx_ovr_set | (ovr & ~stat_clr);
         fe     <= rx_fe_set | (fe & ~stat_clr);
         tx_ovf <= (wr_go && (addr == REG_DATA) && tx_full) | (tx_ovf & ~stat_clr);
      end
   end

   sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .reset(reset), .flush(flush), .push(rx_push), .din(rx_sh_n),
      .pop(rx_pop), .head(rx_head), .empty(rx_empty), .full(rx_full)
   );

   sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .reset(reset), .flush(flush), .push(tx_push), .din(din),
      .pop(tx_pop), .head(tx_head), .empty(tx_empty), .full(tx_full)
   );

   always_comb begin
      rx_next    = rx_state;
      rx_tcnt_n  = rx_tcnt;
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      rx_push    = 1'b0;
      rx_ovr_set = 1'b0;
      rx_fe_set  = 1'b0;
      if (tick16) begin
         case (rx_state)
            S_IDLE: if (!rx_s2) begin
               rx_next   = S_START;
               rx_tcnt_n = '0;
            end
            S_START: if (rx_tcnt == 4'd7) begin
               rx_tcnt_n = '0;
               rx_bit_n  = '0;
               rx_next   = rx_s2 ? S_IDLE : S_DATA;
            end else begin
               rx_tcnt_n = rx_tcnt + 4'd1;
            end
            S_DATA: begin
               rx_tcnt_n = rx_tcnt + 4'd1;
               if (rx_tcnt == 4'd15) begin
                  rx_sh_n  = {rx_s2, rx_sh[7:1]};
                  rx_bit_n = rx_bit + 3'd1;
                  if (rx_bit == 3'd7)
                     rx_next = S_STOP;
               end
            end
            S_STOP: begin
               rx_tcnt_n = rx_tcnt + 4'd1;
               if (rx_tcnt == 4'd15) begin
                  rx_next = S_IDLE;
                  if (!rx_s2)
                     rx_fe_set = 1'b1;
                  else if (rx_full)
                     rx_ovr_set = 1'b1;
                  else
                     rx_push = 1'b1;
               end
            end
         endcase
      end
      if (flush)
         rx_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_state <= S_IDLE;
         rx_tcnt  <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
      end else begin
         rx_s1    <= ctrl[CT_LOOP] ? txd : rxd;
         rx_s2    <= rx_s1;
         rx_state <= rx_next;
         rx_tcnt  <= rx_tcnt_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
      end
   end

   // Stop-bit end reloads straight from the FIFO so back-to-back bytes have no gap.
   always_comb begin
      tx_next   = tx_state;
      tx_tcnt_n = tx_tcnt;
      tx_bit_n  = tx_bit;
      tx_sh_n   = tx_sh;
      tx_pop    = 1'b0;
      case (tx_state)
         S_IDLE: if (tick16 && !tx_empty) begin
            tx_pop    = 1'b1;
            tx_sh_n   = tx_head;
            tx_tcnt_n = '0;
            tx_next   = S_START;
         end
         S_START: if (tick16) begin
            tx_tcnt_n = tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) begin
               tx_bit_n = '0;
               tx_next  = S_DATA;
            end
         end
         S_DATA: if (tick16) begin
            tx_tcnt_n = tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) begin
               tx_sh_n  = {1'b0, tx_sh[7:1]};
               tx_bit_n = tx_bit + 3'd1;
               if (tx_bit == 3'd7)
                  tx_next = S_STOP;
            end
         end
         S_STOP: if (tick16) begin
            tx_tcnt_n = tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) begin
               if (!tx_empty) begin
                  tx_pop  = 1'b1;
                  tx_sh_n = tx_head;
                  tx_next = S_START;
               end else begin
                  tx_next = S_IDLE;
               end
            end
         end
      endcase
      if (flush) begin
         tx_next = S_IDLE;
         tx_pop  = 1'b0;
      end
      txd_n = (tx_next == S_START) ? 1'b0 :
              (tx_next == S_DATA)  ? tx_sh_n[0] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= S_IDLE;
         tx_tcnt  <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         txd      <= 1'b1;
      end else begin
         tx_state <= tx_next;
         tx_tcnt  <= tx_tcnt_n;
         tx_bit   <= tx_bit_n;
         tx_sh    <= tx_sh_n;
         txd      <= txd_n;
      end
   end

   always_comb begin
      dout = 8'h00;
      if (cs) begin
         case (addr)
            REG_STAT: dout = {irq, 1'b0, tx_idle, tx_ovf, fe, ovr, ~tx_full, ~rx_empty};
            REG_DATA: dout = rx_empty ? 8'h00 : rx_head;
            REG_DIVL: dout = div_ext[7:0];
            REG_DIVH: dout = div_ext[15:8];
         endcase
      end
   end
endmodule
